// File: rtl/pc_pkg.sv
// Shared encodings and helpers for the program-counter generator.
package pc_pkg;

  localparam logic [2:0] PC_SRC_SEQ   = 3'b000;
  localparam logic [2:0] PC_SRC_BR    = 3'b001;
  localparam logic [2:0] PC_SRC_J     = 3'b010;
  localparam logic [2:0] PC_SRC_JR    = 3'b011;
  localparam logic [2:0] PC_SRC_ILLOP = 3'b100;
  localparam logic [2:0] PC_SRC_XADR  = 3'b101;

  // Vector entries (illop/xadr) and misaligned JR enter the exception vector path.
  function automatic logic is_exc_class(input logic [2:0] src, input logic misaligned);
    return src[2] | ((src == PC_SRC_JR) & misaligned);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the core control logic and the PC generator.
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             stall;
  logic [2:0]       pc_src;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic [25:0]      jump_index;
  logic [WIDTH-1:0] jr_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             supervisor;
  logic             redirect;
  logic             misalign_exc;
  logic [WIDTH-1:0] epc;

  modport master (
    output stall, pc_src, branch_taken, branch_target, jump_index, jr_target,
    input  pc, pc_plus, supervisor, redirect, misalign_exc, epc
  );

  modport slave (
    input  stall, pc_src, branch_taken, branch_target, jump_index, jr_target,
    output pc, pc_plus, supervisor, redirect, misalign_exc, epc
  );

endinterface

// File: rtl/pc_pending_latch.sv
// Holds a redirect presented while fetch is stalled, so it can be replayed on release.
module pc_pending_latch #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             new_redir_i,
  input  logic             new_exc_i,
  input  logic             new_mis_i,
  input  logic [WIDTH-1:0] new_target_i,
  output logic             pend_valid_o,
  output logic             pend_exc_o,
  output logic             pend_mis_o,
  output logic [WIDTH-1:0] pend_target_o
);

  logic             valid_q, valid_d;
  logic             exc_q, exc_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             capture;

  // A stored exception is never displaced by an ordinary redirect.
  assign capture = stall & new_redir_i & ~(valid_q & exc_q & ~new_exc_i);

  always_comb begin
    valid_d  = valid_q;
    exc_d    = exc_q;
    mis_d    = mis_q;
    target_d = target_q;
    if (stall) begin
      if (capture) begin
        valid_d  = 1'b1;
        exc_d    = new_exc_i;
        mis_d    = new_mis_i;
        target_d = new_target_i;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      exc_q    <= 1'b0;
      mis_q    <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      exc_q    <= exc_d;
      mis_q    <= mis_d;
      target_q <= target_d;
    end
  end

  assign pend_valid_o  = valid_q;
  assign pend_exc_o    = exc_q;
  assign pend_mis_o    = mis_q;
  assign pend_target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// Next-PC selection for the IF stage: sequential, branch, jump, JR and vector entry,
// with stall-time redirect capture, EPC recording and registered flush pulses.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [WIDTH-1:0] XADR_VEC  = 32'h8000_0008,
  parameter int unsigned     STEP      = 4
) (
  input logic       clk,
  input logic       reset,
  pc_gen_if.slave   pc_bus
);

  localparam logic [WIDTH-2:0] StepW = (WIDTH-1)'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             redirect_q, redirect_d;
  logic             mis_q, mis_d;

  logic             sup;
  logic [WIDTH-2:0] pc_plus_low;
  logic             jr_mis;
  logic [WIDTH-1:0] new_target;
  logic             new_redir, new_exc, new_mis;
  logic             pend_valid, pend_exc, pend_mis;
  logic [WIDTH-1:0] pend_target;
  logic             use_pend;
  logic [WIDTH-1:0] apply_target;
  logic             apply_redir, apply_exc, apply_mis;
  logic             unused_bt_msb;

  assign sup           = pc_q[WIDTH-1];
  assign pc_plus_low   = pc_q[WIDTH-2:0] + StepW;
  assign jr_mis        = |pc_bus.jr_target[1:0];
  assign unused_bt_msb = pc_bus.branch_target[WIDTH-1];

  always_comb begin
    new_target = {sup, pc_plus_low};
    new_redir  = 1'b0;
    new_mis    = 1'b0;
    case (pc_bus.pc_src)
      PC_SRC_SEQ: ;
      PC_SRC_BR: begin
        if (pc_bus.branch_taken) begin
          new_target = {sup, pc_bus.branch_target[WIDTH-2:0]};
          new_redir  = 1'b1;
        end
      end
      PC_SRC_J: begin
        new_target = {sup, pc_plus_low[WIDTH-2:28], pc_bus.jump_index, 2'b00};
        new_redir  = 1'b1;
      end
      PC_SRC_JR: begin
        new_target = jr_mis ? XADR_VEC : pc_bus.jr_target;
        new_mis    = jr_mis;
        new_redir  = 1'b1;
      end
      PC_SRC_ILLOP: begin
        new_target = ILLOP_VEC;
        new_redir  = 1'b1;
      end
      default: begin
        new_target = XADR_VEC;
        new_redir  = 1'b1;
      end
    endcase
  end

  assign new_exc = new_redir & is_exc_class(pc_bus.pc_src, jr_mis);

  pc_pending_latch #(
    .WIDTH(WIDTH)
  ) u_pend (
    .clk          (clk),
    .reset        (reset),
    .stall        (pc_bus.stall),
    .new_redir_i  (new_redir),
    .new_exc_i    (new_exc),
    .new_mis_i    (new_mis),
    .new_target_i (new_target),
    .pend_valid_o (pend_valid),
    .pend_exc_o   (pend_exc),
    .pend_mis_o   (pend_mis),
    .pend_target_o(pend_target)
  );

  // On release a new redirect wins unless it would displace a pending exception.
  assign use_pend     = pend_valid & ~(new_redir & ~(pend_exc & ~new_exc));
  assign apply_target = use_pend ? pend_target : new_target;
  assign apply_redir  = use_pend | new_redir;
  assign apply_exc    = use_pend ? pend_exc : new_exc;
  assign apply_mis    = use_pend ? pend_mis : new_mis;

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    mis_d      = 1'b0;
    if (!pc_bus.stall) begin
      pc_d       = apply_target;
      redirect_d = apply_redir;
      mis_d      = apply_mis;
      if (apply_exc) epc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      mis_q      <= mis_d;
    end
  end

  assign pc_bus.pc           = {1'b0, pc_q[WIDTH-2:0]};
  assign pc_bus.pc_plus      = {1'b0, pc_plus_low};
  assign pc_bus.supervisor   = sup;
  assign pc_bus.redirect     = redirect_q;
  assign pc_bus.misalign_exc = mis_q;
  assign pc_bus.epc          = epc_q;

endmodule
